// File: rtl/divisor_circular_seq.sv
// divisor_circular_seq: 4-bit unsigned restoring divider.
// One quotient bit is resolved per clock, MSB first. The results and the
// Z/N/C/V flags are registered once, on the edge that enters DONE.
// A zero divisor spends a single cycle in DIV without iterating and then
// moves straight to DONE with the fixed divide-by-zero result.
module divisor_circular_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] Y,
  output logic [3:0] R,
  output logic       Z,
  output logic       N,
  output logic       C,
  output logic       V,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0] a_reg;
  logic [3:0] b_reg;
  logic [3:0] rem;
  logic [3:0] quo;
  logic [1:0] cnt;

  logic [1:0] bit_idx;
  logic [4:0] rem_shift;
  logic [4:0] rem_sub;
  logic [4:0] rem_step;
  logic       q_bit;
  logic [3:0] quo_step;
  logic       div_zero;
  logic       last_step;

  assign div_zero  = (b_reg == 4'd0);
  assign last_step = (cnt == 2'd3);
  assign bit_idx   = 2'd3 - cnt;

  // One restoring step: shift in the next dividend bit, then subtract B if it fits.
  always_comb begin
    rem_shift = {rem, a_reg[bit_idx]};
    rem_sub   = rem_shift - {1'b0, b_reg};
    q_bit     = (rem_shift >= {1'b0, b_reg});
    rem_step  = q_bit ? rem_sub : rem_shift;
    quo_step  = {quo[2:0], q_bit};
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start only matters in IDLE, DONE always lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = DIV;
        end
      end
      DIV: begin
        if (div_zero || last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status outputs decoded directly from the state.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Operand capture, iteration datapath and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= 4'd0;
      b_reg <= 4'd0;
      rem   <= 4'd0;
      quo   <= 4'd0;
      cnt   <= 2'd0;
      Y     <= 4'd0;
      R     <= 4'd0;
      Z     <= 1'b0;
      N     <= 1'b0;
      C     <= 1'b0;
      V     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            rem   <= 4'd0;
            quo   <= 4'd0;
            cnt   <= 2'd0;
          end
        end
        DIV: begin
          if (div_zero) begin
            Y <= 4'hF;
            R <= a_reg;
            Z <= 1'b0;
            N <= 1'b1;
            C <= 1'b0;
            V <= 1'b1;
          end else begin
            rem <= rem_step[3:0];
            quo <= quo_step;
            cnt <= cnt + 2'd1;
            if (last_step) begin
              Y <= quo_step;
              R <= rem_step[3:0];
              Z <= (quo_step == 4'd0);
              N <= quo_step[3];
              C <= (rem_step != 5'd0);
              V <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_circular_seq.sv
// tb_divisor_circular_seq: scoreboard bench for the sequential divider.
// The stimulus side pushes the expected result for every accepted start;
// the monitor pops and compares on every done pulse, including latency and
// busy duration.
module tb_divisor_circular_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Y;
  logic [3:0] R;
  logic       Z;
  logic       N;
  logic       C;
  logic       V;
  logic       busy;
  logic       done;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int busy_run = 0;

  typedef struct {
    logic [3:0] y;
    logic [3:0] r;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
    int         lat;
    int         due;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  divisor_circular_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .Y    (Y),
    .R    (R),
    .Z    (Z),
    .N    (N),
    .C    (C),
    .V    (V),
    .busy (busy),
    .done (done)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to measure latency from the accepting edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic exp_t mkExp(input logic [3:0] y, input logic [3:0] r,
                                 input logic z, input logic n, input logic c,
                                 input logic v, input int lat, input string tag);
    exp_t e;
    e.y = y; e.r = r; e.z = z; e.n = n; e.c = c; e.v = v;
    e.lat = lat; e.due = 0; e.tag = tag;
    return e;
  endfunction

  // Independent reference model for the sweep
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    string t;
    t = $sformatf("sw_%0d_%0d", a, b);
    if (b == 0) begin
      e = mkExp(4'hF, 4'(a), 1'b0, 1'b1, 1'b0, 1'b1, 1, t);
    end else begin
      e = mkExp(4'(a / b), 4'(a % b), (a / b) == 0, (a / b) >= 8,
                (a % b) != 0, 1'b0, 4, t);
    end
    return e;
  endfunction

  task automatic waitIdle();
    int i;
    i = 0;
    while (busy && i < 50) begin
      @(negedge clk);
      i++;
    end
    if (busy) checkOutput("idle_timeout", 1, 0);
  endtask

  // Issue one start pulse from a falling edge; operands are scrambled afterwards
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input exp_t e);
    exp_t x;
    waitIdle();
    x = e;
    x.due = cyc + 1 + e.lat;
    A = a;
    B = b;
    start = 1'b1;
    exp_q.push_back(x);
    @(negedge clk);
    start = 1'b0;
    A = ~a;
    B = ~b;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_Y"}, int'(Y), 0);
    checkOutput({tag, "_R"}, int'(R), 0);
    checkOutput({tag, "_Z"}, int'(Z), 0);
    checkOutput({tag, "_N"}, int'(N), 0);
    checkOutput({tag, "_C"}, int'(C), 0);
    checkOutput({tag, "_V"}, int'(V), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      else busy_run = 0;
      if (done) begin
        if (exp_q.size() == 0) begin
          checkOutput($sformatf("unexpected_done_at_%0d", cyc), 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput({mon_e.tag, "_Y"}, int'(Y), int'(mon_e.y));
          checkOutput({mon_e.tag, "_R"}, int'(R), int'(mon_e.r));
          checkOutput({mon_e.tag, "_Z"}, int'(Z), int'(mon_e.z));
          checkOutput({mon_e.tag, "_N"}, int'(N), int'(mon_e.n));
          checkOutput({mon_e.tag, "_C"}, int'(C), int'(mon_e.c));
          checkOutput({mon_e.tag, "_V"}, int'(V), int'(mon_e.v));
          checkOutput({mon_e.tag, "_latency"}, cyc, mon_e.due);
          checkOutput({mon_e.tag, "_busy_cycles"}, busy_run, mon_e.lat + 1);
        end
      end
    end
  end

  // Directed scenarios, reset abort and full sweep
  initial begin
    int i;
    rst_n = 1'b0;
    start = 1'b0;
    A = 4'd0;
    B = 4'd0;
    #2;
    checkAllZero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(4'd13, 4'd4, mkExp(4'd3, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4, "d13_4"));
    applyStimulus(4'd15, 4'd1, mkExp(4'd15, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4, "d15_1"));
    applyStimulus(4'd5, 4'd0, mkExp(4'hF, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1, "d5_0"));
    applyStimulus(4'd0, 4'd7, mkExp(4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4, "d0_7"));

    // A second start during DIV must be ignored
    applyStimulus(4'd13, 4'd4, mkExp(4'd3, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4, "repulse"));
    A = 4'd9;
    B = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle();
    repeat (8) @(negedge clk);

    // Reset just before the third DIV edge aborts the operation
    applyStimulus(4'd13, 4'd4, mkExp(4'd3, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4, "aborted"));
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    checkAllZero("abort");
    repeat (2) @(negedge clk);
    checkAllZero("abort_hold");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("abort_no_done_busy", int'(busy), 0);
    applyStimulus(4'd13, 4'd4, mkExp(4'd3, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4, "after_abort"));

    // Exhaustive sweep against the reference model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(4'(a), 4'(b), model(a, b));
      end
    end

    i = 0;
    while (exp_q.size() != 0 && i < 20) begin
      @(negedge clk);
      i++;
    end
    checkOutput("pending_results", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
